disk_chan_arbiter: RTL and testbench
====================================

Name: disk_chan_arbiter

Overview:
- Shares the single ctrl-module disk channel between two wd1770-style requesters (e.g. two controller instances or a controller plus an image-loader).
- Arbitrates the 32-bit dsr/dcr command handshake round-robin, one transaction at a time.
- Routes the byte streams (dd in/out plus strobes) to the current owner.
- A watchdog synthesises an error completion if the host never acknowledges.

Parameters:
TIMEOUT, 24'd12000000, cycles to wait for host ACK before a synthetic ERR completion.
CR_ACK, 4, dcr bit index of host acknowledge.
CR_ERR, 3, dcr bit index of host error flag.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
req0_dsr  in  32  requester 0 command word; [21:17] command bits, [16] ack-of-ack, [12:0] position
req0_dcr  out  32  status returned to requester 0
req0_ddin  out  8  byte from disk to requester 0
req0_ddinclk  out  1  byte strobe to requester 0
req0_ddout  in  8  byte to disk from requester 0
req0_ddoutclk  out  1  read strobe to requester 0 fifo
req1_dsr  in  32  as req0
req1_dcr  out  32  as req0
req1_ddin  out  8  as req0
req1_ddinclk  out  1  as req0
req1_ddout  in  8  as req0
req1_ddoutclk  out  1  as req0
host_dsr  out  32  command word to ctrl-module
host_dcr  in  32  status from ctrl-module
host_ddin  in  8  byte from ctrl-module
host_ddinclk  in  1  byte strobe from ctrl-module
host_ddout  out  8  byte to ctrl-module
host_ddoutclk  in  1  read strobe from ctrl-module
owner  out  2  debug: 00 none, 01 req0, 10 req1

Behaviour:
- pendN = |reqN_dsr[21:17].
- All outputs are registered except the byte path.
- Reset (async, rstn=0):
  - host_dsr, req0_dcr and req1_dcr = 0.
  - owner = 00, state IDLE, last = 1 (req0 wins first), watchdog = 0.
- State IDLE:
  - Only pend0: owner <= 01 next cycle.
  - Only pend1: owner <= 10 next cycle.
  - Both: grant the requester not equal to last; last <= granted.
  - Grant latency is 1 cycle. Go to BUSY.
- State BUSY:
  - host_dsr <= owner's dsr every cycle.
  - Owner's dcr <= host_dcr; the non-owner's dcr is held at 0.
  - Watchdog increments while host_dcr[CR_ACK]=0.
  - On host ACK=1, go to DRAIN.
  - If the watchdog reaches TIMEOUT-1: owner's dcr <= ACK|ERR set (other bits 0), host_dsr <= 0, go to FAKE.
- State DRAIN:
  - Keep forwarding in both directions so the owner sees ACK and raises ack-of-ack.
  - Exit to IDLE when host ACK=0 and owner dsr[21:16]=0 are both true in the same cycle.
  - On exit: host_dsr <= 0, owner's dcr <= 0, owner <= 00, watchdog <= 0.
- State FAKE:
  - Hold the synthetic ACK|ERR to the owner until owner dsr[21:17]=0.
  - Then clear the owner's dcr and go to IDLE. The host is not involved.
- Byte path (combinational, owner-gated):
  - reqN_ddin = host_ddin.
  - reqN_ddinclk = host_ddinclk & (owner==N).
  - reqN_ddoutclk = host_ddoutclk & (owner==N).
  - host_ddout = owner's ddout; 8'h00 when owner=00.
  - Strobes arriving in IDLE are dropped.
- A requester raising commands while not owner is simply ignored until granted; it sees dcr=0.
- Owner dropping its command bits in BUSY before ACK:
  - host_dsr follows the drop.
  - Stay in BUSY until ACK or timeout.
- Only one transaction per grant; after DRAIN, re-arbitration is required even if the same requester is pending again, so fairness holds.
- Reset mid-transaction: everything returns to reset values immediately; no completion is delivered.

Test Plan:
1. pend0 only (req0_dsr=0x00040123), host ACK after 10 cycles then req0 sets bit16, host drops ACK, req0 clears → host_dsr=0x00040123 one cycle after request; req0_dcr[4]=1 mirrored; owner 01→00; req1_dcr stays 0.
2. req0 and req1 assert in the same cycle → req0 granted first (last=1 at reset); after its DRAIN, req1 granted; third simultaneous request goes to req0.
3. Owner req1 in BUSY, host pulses host_ddinclk 512× with bytes 0..255 repeating → req1_ddinclk pulses 512×, req0_ddinclk never pulses; host_ddoutclk routes to req1 and host_ddout = req1_ddout.
4. TIMEOUT=16, host never ACKs → at cycle 16 after grant, req0_dcr = 0x18 and host_dsr=0; req0 clears its command bits → dcr=0, state IDLE.
5. Host returns ACK|ERR (0x18) → owner sees 0x18; drain completes normally; next grant works.
6. Assert rstn=0 during BUSY → outputs 0 asynchronously, owner=00; after release, req0 pending is granted fresh.

Source files
------------

// File: rtl/disk_chan_arbiter.sv
// disk_chan_arbiter
//   Shares one ctrl-module disk channel between two wd1770-style requesters.
//   The 32-bit dsr/dcr command handshake is granted round-robin, one
//   transaction per grant. The byte path is steered combinationally to the
//   current owner. A watchdog fakes an ACK|ERR completion if the host never
//   acknowledges.
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   reqN_dsr / reqN_dcr    requester N command word in / status out (registered)
//   reqN_ddin/_ddinclk     byte and strobe from disk to requester N (owner-gated strobe)
//   reqN_ddout/_ddoutclk   byte from requester N / its fifo read strobe (owner-gated)
//   host_dsr / host_dcr    command word to ctrl-module (registered) / status from it
//   host_ddin/_ddinclk     byte and strobe from ctrl-module
//   host_ddout/_ddoutclk   owner's byte to ctrl-module / read strobe from it
//   owner                  debug: 00 none, 01 req0, 10 req1
module disk_chan_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd12000000,
    parameter int unsigned CR_ACK  = 4,
    parameter int unsigned CR_ERR  = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] req0_dsr,
    output logic [31:0] req0_dcr,
    output logic [7:0]  req0_ddin,
    output logic        req0_ddinclk,
    input  logic [7:0]  req0_ddout,
    output logic        req0_ddoutclk,
    input  logic [31:0] req1_dsr,
    output logic [31:0] req1_dcr,
    output logic [7:0]  req1_ddin,
    output logic        req1_ddinclk,
    input  logic [7:0]  req1_ddout,
    output logic        req1_ddoutclk,
    output logic [31:0] host_dsr,
    input  logic [31:0] host_dcr,
    input  logic [7:0]  host_ddin,
    input  logic        host_ddinclk,
    output logic [7:0]  host_ddout,
    input  logic        host_ddoutclk,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {StIdle, StBusy, StDrain, StFake} state_e;

    localparam logic [31:0] FakeWord = (32'd1 << CR_ACK) | (32'd1 << CR_ERR);

    state_e      state_q, state_d;
    logic [1:0]  owner_q, owner_d;
    logic        last_q, last_d;
    logic [23:0] wd_q, wd_d;
    logic [31:0] host_dsr_q, host_dsr_d;
    logic [31:0] dcr0_q, dcr0_d;
    logic [31:0] dcr1_q, dcr1_d;

    logic        pend0, pend1, grant1;
    logic [31:0] own_dsr;
    logic [31:0] own_dcr_d;

    assign pend0   = |req0_dsr[21:17];
    assign pend1   = |req1_dsr[21:17];
    // When both pend, the one that did not win last time gets the grant.
    assign grant1  = pend1 && (!pend0 || !last_q);
    assign own_dsr = (owner_q == 2'b10) ? req1_dsr : req0_dsr;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        wd_d       = wd_q;
        host_dsr_d = host_dsr_q;
        own_dcr_d  = (owner_q == 2'b10) ? dcr1_q : dcr0_q;

        unique case (state_q)
            StIdle: begin
                own_dcr_d  = '0;
                host_dsr_d = '0;
                wd_d       = '0;
                if (pend0 || pend1) begin
                    owner_d    = grant1 ? 2'b10 : 2'b01;
                    last_d     = grant1;
                    host_dsr_d = grant1 ? req1_dsr : req0_dsr;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                host_dsr_d = own_dsr;
                own_dcr_d  = host_dcr;
                if (host_dcr[CR_ACK]) begin
                    state_d = StDrain;
                end else if (wd_q == TIMEOUT - 24'd1) begin
                    own_dcr_d  = FakeWord;
                    host_dsr_d = '0;
                    state_d    = StFake;
                end else begin
                    wd_d = wd_q + 24'd1;
                end
            end
            StDrain: begin
                if (!host_dcr[CR_ACK] && (own_dsr[21:16] == 6'd0)) begin
                    host_dsr_d = '0;
                    own_dcr_d  = '0;
                    owner_d    = 2'b00;
                    wd_d       = '0;
                    state_d    = StIdle;
                end else begin
                    host_dsr_d = own_dsr;
                    own_dcr_d  = host_dcr;
                end
            end
            StFake: begin
                host_dsr_d = '0;
                if (own_dsr[21:17] == 5'd0) begin
                    own_dcr_d = '0;
                    owner_d   = 2'b00;
                    wd_d      = '0;
                    state_d   = StIdle;
                end else begin
                    own_dcr_d = FakeWord;
                end
            end
            default: state_d = StIdle;
        endcase

        // Non-owner status is always forced to zero.
        dcr0_d = (owner_d == 2'b01) ? own_dcr_d : '0;
        dcr1_d = (owner_d == 2'b10) ? own_dcr_d : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            owner_q    <= 2'b00;
            last_q     <= 1'b1;
            wd_q       <= '0;
            host_dsr_q <= '0;
            dcr0_q     <= '0;
            dcr1_q     <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            wd_q       <= wd_d;
            host_dsr_q <= host_dsr_d;
            dcr0_q     <= dcr0_d;
            dcr1_q     <= dcr1_d;
        end
    end

    assign host_dsr = host_dsr_q;
    assign req0_dcr = dcr0_q;
    assign req1_dcr = dcr1_q;
    assign owner    = owner_q;

    // Byte path is combinational; strobes are dropped when nobody owns the channel.
    always_comb begin
        req0_ddin     = host_ddin;
        req1_ddin     = host_ddin;
        req0_ddinclk  = host_ddinclk & (owner_q == 2'b01);
        req1_ddinclk  = host_ddinclk & (owner_q == 2'b10);
        req0_ddoutclk = host_ddoutclk & (owner_q == 2'b01);
        req1_ddoutclk = host_ddoutclk & (owner_q == 2'b10);
        host_ddout    = 8'h00;
        if (owner_q == 2'b01) host_ddout = req0_ddout;
        if (owner_q == 2'b10) host_ddout = req1_ddout;
    end

endmodule

// File: tb/tb_disk_chan_arbiter.sv
// Testbench for disk_chan_arbiter: randomized transactions checked against a
// transaction-level round-robin model kept in the bench.
module tb_disk_chan_arbiter;

    localparam logic [23:0] TO   = 24'd16;
    localparam logic [31:0] ACKW = 32'h0000_0010;
    localparam logic [31:0] FAKE = 32'h0000_0018;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] req0_dsr = '0, req1_dsr = '0, host_dcr = '0;
    logic [31:0] req0_dcr, req1_dcr, host_dsr;
    logic [7:0]  req0_ddin, req1_ddin, host_ddout;
    logic        req0_ddinclk, req1_ddinclk, req0_ddoutclk, req1_ddoutclk;
    logic [7:0]  req0_ddout = '0, req1_ddout = '0, host_ddin = '0;
    logic        host_ddinclk = 1'b0, host_ddoutclk = 1'b0;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;
    int exp_last = 1;  // model: requester that won the most recent grant

    always #5 clk = ~clk;

    disk_chan_arbiter #(.TIMEOUT(TO), .CR_ACK(4), .CR_ERR(3)) dut (
        .clk(clk), .rstn(rstn),
        .req0_dsr(req0_dsr), .req0_dcr(req0_dcr), .req0_ddin(req0_ddin),
        .req0_ddinclk(req0_ddinclk), .req0_ddout(req0_ddout), .req0_ddoutclk(req0_ddoutclk),
        .req1_dsr(req1_dsr), .req1_dcr(req1_dcr), .req1_ddin(req1_ddin),
        .req1_ddinclk(req1_ddinclk), .req1_ddout(req1_ddout), .req1_ddoutclk(req1_ddoutclk),
        .host_dsr(host_dsr), .host_dcr(host_dcr), .host_ddin(host_ddin),
        .host_ddinclk(host_ddinclk), .host_ddout(host_ddout), .host_ddoutclk(host_ddoutclk),
        .owner(owner)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_dsr(input int who, input logic [31:0] v);
        if (who == 0) req0_dsr = v;
        else req1_dsr = v;
    endtask

    function automatic logic [31:0] dcr_of(input int who);
        return (who == 0) ? req0_dcr : req1_dcr;
    endfunction

    function automatic logic [31:0] rand_cmd();
        logic [31:0] v;
        v = $urandom() & 32'hFFC0_FFFF;
        v[21:17] = 5'($urandom_range(1, 31));
        return v;
    endfunction

    // Round-robin model: lone requester wins; on a tie the one not granted last wins.
    task automatic rr_pick(input bit p0, input bit p1, output int g);
        if (p0 && p1) g = (exp_last == 0) ? 1 : 0;
        else if (p0) g = 0;
        else g = 1;
        exp_last = g;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        req0_dsr = '0; req1_dsr = '0; host_dcr = '0;
        host_ddinclk = 1'b0; host_ddoutclk = 1'b0;
        step(); step();
        rstn = 1'b1;
        exp_last = 1;
    endtask

    // Host ACKs, owner raises ack-of-ack, host drops ACK, owner clears.
    task automatic finish_txn(input int g, input logic [31:0] dsr, input logic [31:0] ackw);
        host_dcr = ackw;
        step();
        checks++;
        if (dcr_of(g) !== ackw) begin
            errors++; $display("FAIL drain_ack: dcr=%h expected %h", dcr_of(g), ackw);
        end
        checks++;
        if (dcr_of(1 - g) !== 32'h0) begin
            errors++; $display("FAIL drain_other_dcr: dcr=%h expected 0", dcr_of(1 - g));
        end
        set_dsr(g, dsr | 32'h0001_0000);
        step();
        checks++;
        if (host_dsr !== (dsr | 32'h0001_0000)) begin
            errors++; $display("FAIL drain_fwd: host_dsr=%h expected %h", host_dsr,
                               dsr | 32'h0001_0000);
        end
        host_dcr = '0;
        step();
        checks++;
        if (owner !== 2'(g + 1) || dcr_of(g) !== 32'h0) begin
            errors++; $display("FAIL drain_hold: owner=%b dcr=%h expected %b 0", owner,
                               dcr_of(g), 2'(g + 1));
        end
        set_dsr(g, 32'h0);
        step();
        checks++;
        if (owner !== 2'b00 || host_dsr !== 32'h0 || dcr_of(g) !== 32'h0) begin
            errors++; $display("FAIL drain_exit: owner=%b host_dsr=%h dcr=%h expected 00 0 0",
                               owner, host_dsr, dcr_of(g));
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        host_ddinclk = 1'b1; host_ddoutclk = 1'b1; req0_ddout = 8'hA5;
        req0_dsr = rand_cmd();
        step(); step(); step();
        checks++;
        if (host_dsr !== 32'h0 || req0_dcr !== 32'h0 || req1_dcr !== 32'h0) begin
            errors++; $display("FAIL reset_regs: host_dsr=%h dcr0=%h dcr1=%h expected 0",
                               host_dsr, req0_dcr, req1_dcr);
        end
        checks++;
        if (owner !== 2'b00) begin
            errors++; $display("FAIL reset_owner: owner=%b expected 00", owner);
        end
        checks++;
        if ({req0_ddinclk, req1_ddinclk, req0_ddoutclk, req1_ddoutclk} !== 4'b0 ||
            host_ddout !== 8'h00) begin
            errors++; $display("FAIL reset_bytes: strobes=%b ddout=%h expected 0000 00",
                               {req0_ddinclk, req1_ddinclk, req0_ddoutclk, req1_ddoutclk},
                               host_ddout);
        end
        host_ddinclk = 1'b0; host_ddoutclk = 1'b0; req0_dsr = '0;
        rstn = 1'b1;
        exp_last = 1;
        step();
    endtask

    task automatic test_single();
        int g;
        logic [31:0] dsr, stat;
        for (int it = 0; it < 4; it++) begin
            dsr  = rand_cmd();
            stat = $urandom() & ~ACKW;
            req0_dsr = dsr;
            host_dcr = stat;
            rr_pick(1'b1, 1'b0, g);
            step();
            checks++;
            if (owner !== 2'b01 || host_dsr !== dsr) begin
                errors++; $display("FAIL single_grant: owner=%b host_dsr=%h expected 01 %h",
                                   owner, host_dsr, dsr);
            end
            repeat ($urandom_range(1, 8)) step();
            checks++;
            if (req0_dcr !== stat || req1_dcr !== 32'h0) begin
                errors++; $display("FAIL single_status: dcr0=%h dcr1=%h expected %h 0",
                                   req0_dcr, req1_dcr, stat);
            end
            finish_txn(g, dsr, stat | ACKW);
        end
    endtask

    task automatic test_round_robin();
        int g, p;
        logic [31:0] d0, d1;
        apply_reset();
        for (int r = 0; r < 10; r++) begin
            if (r == 0 || r == 2) p = 3;
            else if (r == 1 || r == 3) p = 2;
            else p = $urandom_range(1, 3);
            d0 = p[0] ? rand_cmd() : 32'h0;
            d1 = p[1] ? rand_cmd() : 32'h0;
            req0_dsr = d0; req1_dsr = d1;
            rr_pick(p[0], p[1], g);
            step();
            checks++;
            if (owner !== 2'(g + 1) || host_dsr !== ((g == 1) ? d1 : d0)) begin
                errors++; $display("FAIL rr_grant%0d: owner=%b host_dsr=%h expected %b %h", r,
                                   owner, host_dsr, 2'(g + 1), (g == 1) ? d1 : d0);
            end
            finish_txn(g, (g == 1) ? d1 : d0, ACKW | ($urandom() & 32'hFFFF_FFE8));
        end
        req0_dsr = '0; req1_dsr = '0;
        step();
    endtask

    task automatic test_byte_path();
        int g, n0, n1, bad;
        logic [31:0] dsr;
        apply_reset();
        dsr = rand_cmd();
        req1_dsr = dsr;
        rr_pick(1'b0, 1'b1, g);
        step();
        checks++;
        if (owner !== 2'b10) begin
            errors++; $display("FAIL byte_grant: owner=%b expected 10", owner);
        end
        host_dcr = ACKW;
        step();
        n0 = 0; n1 = 0; bad = 0;
        for (int i = 0; i < 512; i++) begin
            host_ddin     = 8'(i);
            host_ddinclk  = 1'b1;
            host_ddoutclk = 1'($urandom_range(0, 1));
            req0_ddout    = 8'($urandom());
            req1_ddout    = 8'($urandom());
            #1;
            if (req1_ddinclk) n1++;
            if (req0_ddinclk) n0++;
            if (req1_ddin !== 8'(i) || req0_ddin !== 8'(i) || host_ddout !== req1_ddout ||
                req1_ddoutclk !== host_ddoutclk || req0_ddoutclk !== 1'b0) bad++;
            step();
            host_ddinclk = 1'b0; host_ddoutclk = 1'b0;
            #1;
            if (req0_ddinclk || req1_ddinclk) bad++;
            step();
        end
        checks++;
        if (n1 !== 512) begin
            errors++; $display("FAIL byte_req1_pulses: got %0d expected 512", n1);
        end
        checks++;
        if (n0 !== 0) begin
            errors++; $display("FAIL byte_req0_pulses: got %0d expected 0", n0);
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL byte_routing: %0d bad samples expected 0", bad);
        end
        finish_txn(g, dsr, ACKW);
        host_ddinclk = 1'b1; host_ddoutclk = 1'b1; req1_ddout = 8'h5A; req0_ddout = 8'hC3;
        #1;
        checks++;
        if ({req0_ddinclk, req1_ddinclk, req0_ddoutclk, req1_ddoutclk} !== 4'b0 ||
            host_ddout !== 8'h00) begin
            errors++; $display("FAIL byte_idle_drop: strobes=%b ddout=%h expected 0000 00",
                               {req0_ddinclk, req1_ddinclk, req0_ddoutclk, req1_ddoutclk},
                               host_ddout);
        end
        host_ddinclk = 1'b0; host_ddoutclk = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int g;
        logic [31:0] dsr;
        apply_reset();
        dsr = rand_cmd();
        req0_dsr = dsr;
        rr_pick(1'b1, 1'b0, g);
        step();
        repeat (int'(TO) - 1) step();
        checks++;
        if (req0_dcr !== 32'h0 || host_dsr !== dsr || owner !== 2'b01) begin
            errors++; $display("FAIL to_before: dcr0=%h host_dsr=%h owner=%b expected 0 %h 01",
                               req0_dcr, host_dsr, owner, dsr);
        end
        step();
        checks++;
        if (req0_dcr !== FAKE || host_dsr !== 32'h0 || req1_dcr !== 32'h0) begin
            errors++; $display("FAIL to_fire: dcr0=%h host_dsr=%h dcr1=%h expected 18 0 0",
                               req0_dcr, host_dsr, req1_dcr);
        end
        host_dcr = ACKW;
        repeat (3) step();
        checks++;
        if (req0_dcr !== FAKE || owner !== 2'b01 || host_dsr !== 32'h0) begin
            errors++; $display("FAIL to_hold: dcr0=%h owner=%b host_dsr=%h expected 18 01 0",
                               req0_dcr, owner, host_dsr);
        end
        // Ack-of-ack alone still counts as cleared for the synthetic completion.
        req0_dsr = (dsr & 32'hFFC1_FFFF) | 32'h0001_0000;
        step();
        checks++;
        if (req0_dcr !== 32'h0 || owner !== 2'b00) begin
            errors++; $display("FAIL to_exit: dcr0=%h owner=%b expected 0 00", req0_dcr, owner);
        end
        req0_dsr = '0; host_dcr = '0;
        // Owner drops its command early: host_dsr follows, watchdog still fires.
        dsr = rand_cmd();
        req1_dsr = dsr;
        rr_pick(1'b0, 1'b1, g);
        step();
        step();
        req1_dsr = '0;
        step();
        checks++;
        if (host_dsr !== 32'h0 || owner !== 2'b10) begin
            errors++; $display("FAIL drop_follow: host_dsr=%h owner=%b expected 0 10",
                               host_dsr, owner);
        end
        repeat (int'(TO) - 3) step();
        checks++;
        if (owner !== 2'b10 || req1_dcr !== 32'h0) begin
            errors++; $display("FAIL drop_busy: owner=%b dcr1=%h expected 10 0", owner, req1_dcr);
        end
        step();
        checks++;
        if (req1_dcr !== FAKE) begin
            errors++; $display("FAIL drop_fire: dcr1=%h expected 18", req1_dcr);
        end
        step();
        checks++;
        if (req1_dcr !== 32'h0 || owner !== 2'b00) begin
            errors++; $display("FAIL drop_exit: dcr1=%h owner=%b expected 0 00", req1_dcr, owner);
        end
    endtask

    task automatic test_err_status();
        int g;
        logic [31:0] dsr;
        dsr = rand_cmd();
        req0_dsr = dsr;
        rr_pick(1'b1, 1'b0, g);
        step();
        checks++;
        if (owner !== 2'b01) begin
            errors++; $display("FAIL err_grant: owner=%b expected 01", owner);
        end
        finish_txn(g, dsr, FAKE);
        dsr = rand_cmd();
        req1_dsr = dsr;
        rr_pick(1'b0, 1'b1, g);
        step();
        checks++;
        if (owner !== 2'b10 || host_dsr !== dsr) begin
            errors++; $display("FAIL err_next: owner=%b host_dsr=%h expected 10 %h",
                               owner, host_dsr, dsr);
        end
        finish_txn(g, dsr, ACKW);
    endtask

    task automatic test_reset_mid();
        int g;
        logic [31:0] dsr, stat;
        dsr  = rand_cmd();
        stat = $urandom() & ~ACKW;
        req0_dsr = dsr;
        host_dcr = stat;
        rr_pick(1'b1, 1'b0, g);
        step(); step();
        checks++;
        if (req0_dcr !== stat || host_dsr !== dsr) begin
            errors++; $display("FAIL mid_busy: dcr0=%h host_dsr=%h expected %h %h",
                               req0_dcr, host_dsr, stat, dsr);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (host_dsr !== 32'h0 || req0_dcr !== 32'h0 || owner !== 2'b00) begin
            errors++; $display("FAIL mid_async: host_dsr=%h dcr0=%h owner=%b expected 0 0 00",
                               host_dsr, req0_dcr, owner);
        end
        step(); step();
        host_dcr = '0;
        rstn = 1'b1;
        exp_last = 1;
        rr_pick(1'b1, 1'b0, g);
        step();
        checks++;
        if (owner !== 2'b01 || host_dsr !== dsr) begin
            errors++; $display("FAIL mid_regrant: owner=%b host_dsr=%h expected 01 %h",
                               owner, host_dsr, dsr);
        end
        finish_txn(g, dsr, ACKW);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_byte_path();
        test_timeout();
        test_err_status();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
